// File: rtl/player_physics_pkg.sv
// Shared definitions for the player physics path.
//   pix_t / player_box_t / plat_desc_t : pixel coordinate and bus payloads
//   scan_state_t                       : ground-collider scheduler states
package player_physics_pkg;

  localparam int unsigned PIX_W             = 10;
  localparam int unsigned NUM_PLATFORMS_DEF = 8;
  localparam int unsigned FOOT_TOL_DEF      = 2;

  typedef logic [PIX_W-1:0] pix_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SCAN   = 2'd1,
    DRAIN  = 2'd2,
    UPDATE = 2'd3
  } scan_state_t;

  typedef struct packed {
    pix_t x;
    pix_t y;
    pix_t w;
    pix_t h;
  } player_box_t;

  typedef struct packed {
    logic valid;
    pix_t x0;
    pix_t x1;
    pix_t y;
  } plat_desc_t;

endpackage

// File: rtl/player_ground_collider_scheduler_cmp.sv
// Combinational ground test for one platform descriptor.
//   player       : latched player box
//   plat         : descriptor returned by the platform store
//   best_valid/y : current best candidate
//   is_candidate : platform overlaps the player horizontally and sits at/under the feet
//   is_better    : candidate strictly higher (smaller y) than the current best
module player_ground_candidate_cmp
  import player_physics_pkg::*;
#(
  parameter int unsigned FOOT_TOL = FOOT_TOL_DEF
) (
  input  player_box_t player,
  input  plat_desc_t  plat,
  input  logic        best_valid,
  input  pix_t        best_y,
  output logic        is_candidate,
  output logic        is_better
);

  localparam int unsigned SUM_W = PIX_W + 1;

  logic [SUM_W-1:0] player_right;
  logic [SUM_W-1:0] player_feet;
  logic [SUM_W-1:0] plat_top_tol;

  // Sums widened by one bit so they never wrap.
  always_comb begin
    player_right = SUM_W'(player.x) + SUM_W'(player.w);
    player_feet  = SUM_W'(player.y) + SUM_W'(player.h);
    plat_top_tol = SUM_W'(plat.y) + SUM_W'(FOOT_TOL);
    is_candidate = plat.valid
                && (SUM_W'(plat.x0) < player_right)
                && (plat.x1 > player.x)
                && (plat_top_tol >= player_feet);
    // Strict compare: in index order, the first of equal heights is kept.
    is_better    = is_candidate && (!best_valid || (plat.y < best_y));
  end

endmodule

// File: rtl/player_ground_collider_scheduler.sv
// Time-multiplexed ground-collision arbiter: scans the platform store and
// reports the topmost platform under the player's feet.
//   scan_start                  : single-cycle scan request (ignored while busy)
//   player_pos_x/y, player_w/h  : player box, latched at scan start
//   plat_rd_en / plat_idx       : platform store read port
//   plat_valid/x0/x1/y          : descriptor, one cycle after plat_rd_en
//   collider_ground_h_player    : selected ground top (0 when none)
//   is_collider_ground_player   : a ground platform was selected
//   scan_busy / scan_done       : scan in progress / result-update pulse
module player_ground_collider_scheduler
  import player_physics_pkg::*;
#(
  parameter int unsigned NUM_PLATFORMS = NUM_PLATFORMS_DEF,
  parameter int unsigned IDX_W         = 3,
  parameter int unsigned FOOT_TOL      = FOOT_TOL_DEF
) (
  input  logic             clk_player_control,
  input  logic             reset,
  input  logic             scan_start,
  input  logic [PIX_W-1:0] player_pos_x,
  input  logic [PIX_W-1:0] player_pos_y,
  input  logic [PIX_W-1:0] player_w,
  input  logic [PIX_W-1:0] player_h,
  output logic             plat_rd_en,
  output logic [IDX_W-1:0] plat_idx,
  input  logic             plat_valid,
  input  logic [PIX_W-1:0] plat_x0,
  input  logic [PIX_W-1:0] plat_x1,
  input  logic [PIX_W-1:0] plat_y,
  output logic [PIX_W-1:0] collider_ground_h_player,
  output logic             is_collider_ground_player,
  output logic             scan_busy,
  output logic             scan_done
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_PLATFORMS - 1);

  scan_state_t      state;
  scan_state_t      next_state;
  player_box_t      snap;
  plat_desc_t       desc;
  logic             rd_valid_d;
  logic [IDX_W-1:0] eval_idx;
  logic             best_valid;
  pix_t             best_y;
  logic [IDX_W-1:0] best_idx;
  logic             is_candidate;
  logic             is_better;
  logic             take;
  logic             best_valid_nxt;
  pix_t             best_y_nxt;

  assign desc = '{valid: plat_valid, x0: plat_x0, x1: plat_x1, y: plat_y};

  player_ground_candidate_cmp #(
    .FOOT_TOL (FOOT_TOL)
  ) u_cmp (
    .player       (snap),
    .plat         (desc),
    .best_valid   (best_valid),
    .best_y       (best_y),
    .is_candidate (is_candidate),
    .is_better    (is_better)
  );

  // Next state and the best candidate including the descriptor now on the bus.
  always_comb begin
    next_state     = state;
    take           = rd_valid_d && is_better;
    best_valid_nxt = best_valid;
    best_y_nxt     = best_y;
    if (take) begin
      best_valid_nxt = 1'b1;
      best_y_nxt     = plat_y;
    end
    case (state)
      IDLE:    if (scan_start) next_state = SCAN;
      SCAN:    if (plat_idx == LAST_IDX) next_state = DRAIN;
      DRAIN:   next_state = UPDATE;
      UPDATE:  next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // State, read port, best registers and registered outputs.
  always_ff @(posedge clk_player_control) begin
    if (reset) begin
      state                     <= IDLE;
      snap                      <= '0;
      plat_rd_en                <= 1'b0;
      plat_idx                  <= '0;
      rd_valid_d                <= 1'b0;
      eval_idx                  <= '0;
      best_valid                <= 1'b0;
      best_y                    <= '0;
      best_idx                  <= '0;
      collider_ground_h_player  <= '0;
      is_collider_ground_player <= 1'b0;
      scan_busy                 <= 1'b0;
      scan_done                 <= 1'b0;
    end else begin
      state      <= next_state;
      plat_rd_en <= (next_state == SCAN);
      scan_busy  <= (next_state != IDLE);
      scan_done  <= (state == DRAIN);
      rd_valid_d <= plat_rd_en;
      eval_idx   <= plat_idx;

      if (state == IDLE && scan_start) begin
        snap       <= '{x: player_pos_x, y: player_pos_y, w: player_w, h: player_h};
        plat_idx   <= '0;
        best_valid <= 1'b0;
        best_y     <= '0;
        best_idx   <= '0;
      end else begin
        if (state == SCAN) plat_idx <= (plat_idx == LAST_IDX) ? '0 : plat_idx + 1'b1;
        if (take) begin
          best_valid <= 1'b1;
          best_y     <= plat_y;
          best_idx   <= eval_idx;
        end
      end

      // Loaded on the edge into UPDATE so results are valid with scan_done.
      if (state == DRAIN) begin
        is_collider_ground_player <= best_valid_nxt;
        collider_ground_h_player  <= best_valid_nxt ? best_y_nxt : '0;
      end
    end
  end

endmodule

// File: tb/tb_player_ground_collider_scheduler.sv
module tb_player_ground_collider_scheduler;

  logic       clk_player_control = 1'b0;
  logic       reset = 1'b1;
  logic       scan_start = 1'b0;
  logic [9:0] player_pos_x = 10'd320;
  logic [9:0] player_pos_y = 10'd240;
  logic [9:0] player_w = 10'd30;
  logic [9:0] player_h = 10'd30;
  logic       plat_rd_en;
  logic [2:0] plat_idx;
  logic       plat_valid = 1'b0;
  logic [9:0] plat_x0 = '0;
  logic [9:0] plat_x1 = '0;
  logic [9:0] plat_y = '0;
  logic [9:0] collider_ground_h_player;
  logic       is_collider_ground_player;
  logic       scan_busy;
  logic       scan_done;

  int total = 0;
  int bad = 0;

  logic       st_valid [8];
  logic [9:0] st_x0 [8];
  logic [9:0] st_x1 [8];
  logic [9:0] st_y [8];

  player_ground_collider_scheduler dut (
    .clk_player_control        (clk_player_control),
    .reset                     (reset),
    .scan_start                (scan_start),
    .player_pos_x              (player_pos_x),
    .player_pos_y              (player_pos_y),
    .player_w                  (player_w),
    .player_h                  (player_h),
    .plat_rd_en                (plat_rd_en),
    .plat_idx                  (plat_idx),
    .plat_valid                (plat_valid),
    .plat_x0                   (plat_x0),
    .plat_x1                   (plat_x1),
    .plat_y                    (plat_y),
    .collider_ground_h_player  (collider_ground_h_player),
    .is_collider_ground_player (is_collider_ground_player),
    .scan_busy                 (scan_busy),
    .scan_done                 (scan_done)
  );

  always #5 clk_player_control = ~clk_player_control;

  // Platform store: registered read, one cycle latency.
  always @(posedge clk_player_control) begin
    if (plat_rd_en) begin
      plat_valid <= st_valid[plat_idx];
      plat_x0    <= st_x0[plat_idx];
      plat_x1    <= st_x1[plat_idx];
      plat_y     <= st_y[plat_idx];
    end
  end

  task automatic clear_store();
    for (int i = 0; i < 8; i++) begin
      st_valid[i] = 1'b0;
      st_x0[i] = 10'd0;
      st_x1[i] = 10'd0;
      st_y[i] = 10'd0;
    end
  endtask

  task automatic set_plat(input int idx, input int x0, input int x1, input int y);
    st_valid[idx] = 1'b1;
    st_x0[idx] = 10'(x0);
    st_x1[idx] = 10'(x1);
    st_y[idx] = 10'(y);
  endtask

  // Issue one scan and observe 20 cycles. Player inputs are scrambled after
  // the start edge; a restart request or reset pulse can be injected.
  task automatic run_scan(input int restart_cyc, input int reset_cyc,
                          output int done_cyc, output int done_cnt,
                          output int busy_bad, output logic zero_ok);
    logic [9:0] sx, sy;
    done_cyc = 0; done_cnt = 0; busy_bad = 0; zero_ok = 1'b0;
    sx = player_pos_x; sy = player_pos_y;
    @(negedge clk_player_control);
    scan_start = 1'b1;
    @(negedge clk_player_control);
    scan_start = 1'b0;
    player_pos_x = 10'd0;
    player_pos_y = 10'd900;
    for (int c = 1; c <= 20; c++) begin
      if (scan_done) begin
        done_cnt++;
        if (done_cyc == 0) done_cyc = c;
      end
      if (reset_cyc == 0 && c <= 10 && !scan_busy) busy_bad++;
      if (reset_cyc != 0 && c == reset_cyc + 1)
        zero_ok = !plat_rd_en && plat_idx == 3'd0 && collider_ground_h_player == 10'd0 &&
                  !is_collider_ground_player && !scan_busy && !scan_done;
      scan_start = (c == restart_cyc);
      reset = (c == reset_cyc);
      @(negedge clk_player_control);
    end
    scan_start = 1'b0;
    reset = 1'b0;
    player_pos_x = sx;
    player_pos_y = sy;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk_player_control);
    reset = 1'b0;
    @(negedge clk_player_control);
    total++; if (collider_ground_h_player !== 10'd0) begin bad++; $display("FAIL reset_ground_h: got %0d expected 0", collider_ground_h_player); end
    total++; if (is_collider_ground_player !== 1'b0) begin bad++; $display("FAIL reset_is_collider: got %0b expected 0", is_collider_ground_player); end
    total++; if (scan_busy !== 1'b0 || scan_done !== 1'b0) begin bad++; $display("FAIL reset_busy_done: got %0b/%0b expected 0/0", scan_busy, scan_done); end
    total++; if (plat_rd_en !== 1'b0 || plat_idx !== 3'd0) begin bad++; $display("FAIL reset_rd: got %0b/%0d expected 0/0", plat_rd_en, plat_idx); end
  endtask

  task automatic test_single();
    int dc, dn, bb; logic z;
    clear_store();
    set_plat(2, 300, 400, 300);
    run_scan(0, 0, dc, dn, bb, z);
    total++; if (dc != 10) begin bad++; $display("FAIL single_done_cycle: got %0d expected 10", dc); end
    total++; if (dn != 1) begin bad++; $display("FAIL single_done_width: got %0d expected 1", dn); end
    total++; if (bb != 0) begin bad++; $display("FAIL single_busy: got %0d idle cycles expected 0", bb); end
    total++; if (is_collider_ground_player !== 1'b1) begin bad++; $display("FAIL single_is_collider: got %0b expected 1", is_collider_ground_player); end
    total++; if (collider_ground_h_player !== 10'd300) begin bad++; $display("FAIL single_ground_h: got %0d expected 300", collider_ground_h_player); end
  endtask

  task automatic test_priority();
    int dc, dn, bb; logic z;
    clear_store();
    set_plat(1, 300, 400, 300);
    set_plat(5, 300, 400, 280);
    run_scan(0, 0, dc, dn, bb, z);
    total++; if (collider_ground_h_player !== 10'd280) begin bad++; $display("FAIL prio_two: got %0d expected 280", collider_ground_h_player); end
    set_plat(3, 300, 400, 220);
    run_scan(0, 0, dc, dn, bb, z);
    total++; if (collider_ground_h_player !== 10'd280 || is_collider_ground_player !== 1'b1) begin bad++; $display("FAIL prio_above_feet: got %0d/%0b expected 280/1", collider_ground_h_player, is_collider_ground_player); end
  endtask

  task automatic test_tolerance();
    int dc, dn, bb; logic z;
    clear_store();
    set_plat(6, 300, 400, 268);
    run_scan(0, 0, dc, dn, bb, z);
    total++; if (collider_ground_h_player !== 10'd268 || is_collider_ground_player !== 1'b1) begin bad++; $display("FAIL tol_268: got %0d/%0b expected 268/1", collider_ground_h_player, is_collider_ground_player); end
    st_y[6] = 10'd267;
    run_scan(0, 0, dc, dn, bb, z);
    total++; if (collider_ground_h_player !== 10'd0 || is_collider_ground_player !== 1'b0) begin bad++; $display("FAIL tol_267: got %0d/%0b expected 0/0", collider_ground_h_player, is_collider_ground_player); end
  endtask

  task automatic test_tie();
    int dc, dn, bb; logic z;
    clear_store();
    set_plat(0, 300, 330, 300);
    set_plat(4, 340, 400, 300);
    run_scan(0, 0, dc, dn, bb, z);
    total++; if (collider_ground_h_player !== 10'd300) begin bad++; $display("FAIL tie_ground_h: got %0d expected 300", collider_ground_h_player); end
    total++; if (dut.best_idx !== 3'd0) begin bad++; $display("FAIL tie_best_idx: got %0d expected 0", dut.best_idx); end
  endtask

  task automatic test_hboundary();
    int dc, dn, bb; logic z;
    clear_store();
    set_plat(7, 200, 320, 300);
    run_scan(0, 0, dc, dn, bb, z);
    total++; if (is_collider_ground_player !== 1'b0 || collider_ground_h_player !== 10'd0) begin bad++; $display("FAIL hb_x1_eq_px: got %0b/%0d expected 0/0", is_collider_ground_player, collider_ground_h_player); end
    st_x1[7] = 10'd321;
    run_scan(0, 0, dc, dn, bb, z);
    total++; if (is_collider_ground_player !== 1'b1 || collider_ground_h_player !== 10'd300) begin bad++; $display("FAIL hb_x1_321: got %0b/%0d expected 1/300", is_collider_ground_player, collider_ground_h_player); end
    clear_store();
    set_plat(7, 350, 400, 300);
    run_scan(0, 0, dc, dn, bb, z);
    total++; if (is_collider_ground_player !== 1'b0) begin bad++; $display("FAIL hb_x0_eq_right: got %0b expected 0", is_collider_ground_player); end
  endtask

  task automatic test_restart_ignored();
    int dc, dn, bb; logic z;
    clear_store();
    set_plat(2, 300, 400, 300);
    run_scan(3, 0, dc, dn, bb, z);
    total++; if (dc != 10 || dn != 1) begin bad++; $display("FAIL restart_done: got cycle %0d count %0d expected 10/1", dc, dn); end
    total++; if (collider_ground_h_player !== 10'd300) begin bad++; $display("FAIL restart_ground_h: got %0d expected 300", collider_ground_h_player); end
  endtask

  task automatic test_reset_mid_scan();
    int dc, dn, bb; logic z;
    clear_store();
    set_plat(2, 300, 400, 290);
    run_scan(0, 5, dc, dn, bb, z);
    total++; if (z !== 1'b1) begin bad++; $display("FAIL midreset_zero: got %0b expected 1", z); end
    total++; if (dn != 0) begin bad++; $display("FAIL midreset_no_done: got %0d pulses expected 0", dn); end
    run_scan(0, 0, dc, dn, bb, z);
    total++; if (dc != 10 || collider_ground_h_player !== 10'd290 || is_collider_ground_player !== 1'b1) begin bad++; $display("FAIL midreset_fresh: got cycle %0d h %0d c %0b expected 10/290/1", dc, collider_ground_h_player, is_collider_ground_player); end
  endtask

  initial begin
    clear_store();
    test_reset();
    test_single();
    test_priority();
    test_tolerance();
    test_tie();
    test_hboundary();
    test_restart_ignored();
    test_reset_mid_scan();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
